// File: rtl/menu_input.sv
`default_nettype none
// ============================================================================
// Module   : menu_input
// Purpose  : Joystick front end that syncs and debounces button/up/down and
//            produces the enter pulse and Pause Menu selection for the main FSM.
// Revision : 1.0 - initial release
// ============================================================================
module menu_input #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    input  logic joy_up,
    input  logic joy_down,
    input  logic menu_active,
    output logic enter,
    output logic value,
    output logic button_level
);

    localparam int                  c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                  c_BTN      = 0;
    localparam int                  c_UP       = 1;
    localparam int                  c_DN       = 2;

    logic [2:0] w_raw;
    logic [2:0] w_db;
    logic [2:0] w_rise;
    logic [2:0] r_db_q;
    logic       r_enter;
    logic       r_value;
    logic       r_button_level;

    assign w_raw = {joy_down, joy_up, button};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic               r_sync1;
            logic               r_sync2;
            logic               r_db;
            logic [c_CNT_W-1:0] r_cnt;

            // The counter only advances while the synced input disagrees with
            // the debounced level; reaching the limit commits the new level.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_db  <= ~r_db;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_db[gi] = r_db;
        end
    endgenerate

    assign w_rise = w_db & ~r_db_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_db_q         <= 3'b000;
            r_enter        <= 1'b0;
            r_value        <= 1'b0;
            r_button_level <= 1'b0;
        end else begin
            r_db_q         <= w_db;
            r_enter        <= w_rise[c_BTN];
            r_button_level <= w_db[c_BTN];
            // Selection is frozen while enter is being generated so the FSM
            // samples a stable value; a closed menu forces Continue.
            if (!menu_active) begin
                r_value <= 1'b0;
            end else if (w_rise[c_BTN]) begin
                r_value <= r_value;
            end else if (w_rise[c_UP] && w_rise[c_DN]) begin
                r_value <= r_value;
            end else if (w_rise[c_DN]) begin
                r_value <= 1'b1;
            end else if (w_rise[c_UP]) begin
                r_value <= 1'b0;
            end
        end
    end

    assign enter        = r_enter;
    assign value        = r_value;
    assign button_level = r_button_level;

endmodule
`default_nettype wire
